// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared fetch-stage constants and state encoding
package pipe_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;
  localparam logic [31:0] INST_NOP       = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT,
    IDLE,
    WAIT,
    DROP
  } fetch_state_t;

endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - two-entry {pc, inst} buffer whose head feeds the ID stage
module fetch_buf
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        push,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_inst,
  input  logic        pop,
  input  logic        flush,
  output logic [1:0]  count,
  output logic        head_valid,
  output logic [31:0] head_pc,
  output logic [31:0] head_inst
);
  logic [31:0] tail_pc;
  logic [31:0] tail_inst;
  logic        pop_ok;
  logic        push_ok;

  assign head_valid = (count != 2'd0);
  assign pop_ok     = pop && head_valid;
  assign push_ok    = push && ((count != 2'd2) || pop_ok);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count     <= 2'd0;
      head_pc   <= 32'h0;
      head_inst <= INST_NOP;
      tail_pc   <= 32'h0;
      tail_inst <= INST_NOP;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) begin
            head_pc   <= push_pc;
            head_inst <= push_inst;
          end else begin
            tail_pc   <= push_pc;
            tail_inst <= push_inst;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_pc   <= tail_pc;
          head_inst <= tail_inst;
          count     <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_pc   <= push_pc;
            head_inst <= push_inst;
          end else begin
            head_pc   <= tail_pc;
            head_inst <= tail_inst;
            tail_pc   <= push_pc;
            tail_inst <= push_inst;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// rtl/fetch_pc_ctrl.sv - fetch PC sequencer with delay-slot aware redirect
// Exception vectoring is enabled by defining FETCH_EXC_VECTOR_EN.
module fetch_pc_ctrl
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
`ifdef FETCH_EXC_VECTOR_EN
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
`endif
  parameter int          BUF_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i,
`ifdef FETCH_EXC_VECTOR_EN
  input  logic        exc_valid_i,
`endif
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o
);
  localparam logic [1:0] DEPTH = BUF_DEPTH[1:0];

  fetch_state_t state;
  logic [31:0]  fetch_pc;
  logic [31:0]  pend_target;
  logic         pend_valid;
  logic [1:0]   count;
  logic [1:0]   occupancy;
  logic         exc;
  logic         outstanding;
  logic         ack;
  logic         push;
  logic         pop;
  logic         accept;

`ifdef FETCH_EXC_VECTOR_EN
  assign exc = exc_valid_i;
`else
  assign exc = 1'b0;
`endif

  assign outstanding = (state == WAIT);
  assign occupancy   = count + {1'b0, outstanding};
  assign ack         = outstanding && imem_ack_i;
  assign push        = ack && !exc;
  assign pop         = if_valid_o && !stall_i && !exc;
  assign accept      = pop && redirect_valid_i;

  fetch_buf u_buf (
    .clk        (clk),
    .resetn     (resetn),
    .push       (push),
    .push_pc    (imem_addr_o),
    .push_inst  (imem_rdata_i),
    .pop        (pop),
    .flush      (exc),
    .count      (count),
    .head_valid (if_valid_o),
    .head_pc    (if_pc_o),
    .head_inst  (if_inst_o)
  );

  // fetch_pc tracks the in-flight address until its ack, so a redirect whose
  // delay slot is still outstanding is parked in pend_target until that ack.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= BOOT;
      imem_req_o  <= 1'b0;
      imem_addr_o <= RESET_PC;
      fetch_pc    <= RESET_PC;
      pend_target <= RESET_PC;
      pend_valid  <= 1'b0;
    end else begin
`ifdef FETCH_EXC_VECTOR_EN
      if (exc) begin
        fetch_pc   <= EXC_VECTOR;
        pend_valid <= 1'b0;
      end else
`endif
      if (accept && ((count == 2'd2) || ack)) begin
        fetch_pc <= redirect_target_i;
      end else if (accept) begin
        pend_target <= redirect_target_i;
        pend_valid  <= 1'b1;
      end else if (push) begin
        if (pend_valid) begin
          fetch_pc   <= pend_target;
          pend_valid <= 1'b0;
        end else begin
          fetch_pc <= fetch_pc + 32'd4;
        end
      end

      case (state)
        BOOT: state <= IDLE;
        IDLE: begin
          if (!exc && (occupancy < DEPTH)) begin
            imem_req_o  <= 1'b1;
            imem_addr_o <= fetch_pc;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (imem_ack_i) begin
            imem_req_o <= 1'b0;
            state      <= IDLE;
          end else if (exc) begin
            state <= DROP;
          end
        end
`ifdef FETCH_EXC_VECTOR_EN
        DROP: begin
          if (imem_ack_i) begin
            imem_req_o <= 1'b0;
            state      <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
